// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared constants and types for the memory-mapped IO responder:
//   - default bus width and FIFO depth
//   - register addresses (COUNT, CMP, CTRL, STATUS, FIFO)
//   - CTRL / STATUS bit indices and the CTRL register layout
// -----------------------------------------------------------------------------
package io_pkg;

   localparam int unsigned IO_LEN    = 16;
   localparam int unsigned IO_FDEPTH = 4;

   // Register map: 0x0-0x7 are scratch, 0xD-0xF are unmapped.
   localparam logic [3:0] A_COUNT  = 4'h8;
   localparam logic [3:0] A_CMP    = 4'h9;
   localparam logic [3:0] A_CTRL   = 4'hA;
   localparam logic [3:0] A_STATUS = 4'hB;
   localparam logic [3:0] A_FIFO   = 4'hC;

   localparam int unsigned CTRL_TMR_EN   = 0;
   localparam int unsigned CTRL_IRQ_EN   = 1;
   localparam int unsigned CTRL_AUTO_CLR = 2;

   localparam int unsigned ST_MATCH  = 0;
   localparam int unsigned ST_EMPTY  = 1;
   localparam int unsigned ST_FULL   = 2;
   localparam int unsigned ST_OVF    = 3;
   localparam int unsigned ST_CNT_LO = 4;  // fifo count occupies [6:4]
   localparam int unsigned ST_UNF    = 7;

   typedef struct packed {
      logic auto_clr;
      logic irq_en;
      logic tmr_en;
   } ctrl_t;

   function automatic logic is_scratch(input logic [3:0] a);
      return ~a[3];
   endfunction

endpackage

// File: rtl/io_fifo.sv
// -----------------------------------------------------------------------------
// io_fifo
// Small synchronous FIFO used as the responder's mailbox register.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (pointers/count only)
//   push, din      write request and data; ignored when full
//   pop            read request; ignored when empty
//   dout           head entry (combinational, only meaningful when !empty)
//   empty, full    occupancy flags
//   count          number of stored entries, 0..DEPTH
// DEPTH must be a power of two so pointers wrap naturally.
// -----------------------------------------------------------------------------
module io_fifo #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; contents are only visible through the head
   // when count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder
// Memory-mapped peripheral on the IO controller bus: eight scratch registers,
// a free-running timer with compare/auto-clear, sticky status flags and a
// mailbox FIFO.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en_cs      device select
//   en_w       write strobe (1 = write, 0 = read when selected)
//   addr       register address
//   data_i     write data
//   data_o     combinational read data, 0 when not driving
//   data_oe    bus drive enable (en_cs & ~en_w); tri-stating is done above
//   irq        STATUS.match & CTRL.irq_en
// -----------------------------------------------------------------------------
module io_responder
   import io_pkg::*;
#(
   parameter int unsigned LEN    = IO_LEN,
   parameter int unsigned FDEPTH = IO_FDEPTH
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en_cs,
   input  logic           en_w,
   input  logic [3:0]     addr,
   input  logic [LEN-1:0] data_i,
   output logic [LEN-1:0] data_o,
   output logic           data_oe,
   output logic           irq
);

   localparam int unsigned CW = $clog2(FDEPTH + 1);

   logic [LEN-1:0] scratch_q [8];
   logic [LEN-1:0] count_q, count_d;
   logic [LEN-1:0] cmp_q, cmp_d;
   ctrl_t          ctrl_q, ctrl_d;
   logic           match_q, match_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;

   logic           wr, rd;
   logic           wr_status, wr_fifo, rd_fifo;
   logic           match_hit;
   logic [7:0]     status_v;
   logic [LEN-1:0] rdata;

   logic           f_push, f_pop, f_empty, f_full;
   logic [LEN-1:0] f_dout;
   logic [CW-1:0]  f_count;

   assign wr        = en_cs & en_w;
   assign rd        = en_cs & ~en_w;
   assign wr_status = wr & (addr == A_STATUS);
   assign wr_fifo   = wr & (addr == A_FIFO);
   assign rd_fifo   = rd & (addr == A_FIFO);
   assign match_hit = ctrl_q.tmr_en & (count_q == cmp_q);

   assign f_push = wr_fifo & ~f_full;
   assign f_pop  = rd_fifo & ~f_empty;

   io_fifo #(
      .W     (LEN),
      .DEPTH (FDEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (f_push),
      .pop   (f_pop),
      .din   (data_i),
      .dout  (f_dout),
      .empty (f_empty),
      .full  (f_full),
      .count (f_count)
   );

   always_comb begin
      count_d = count_q;
      cmp_d   = cmp_q;
      ctrl_d  = ctrl_q;

      // Bus write to COUNT takes priority over both increment and auto-clear.
      if (wr && addr == A_COUNT) begin
         count_d = data_i;
      end else if (ctrl_q.tmr_en) begin
         count_d = (match_hit && ctrl_q.auto_clr) ? '0 : count_q + LEN'(1);
      end

      if (wr && addr == A_CMP) cmp_d = data_i;

      if (wr && addr == A_CTRL) begin
         ctrl_d.tmr_en   = data_i[CTRL_TMR_EN];
         ctrl_d.irq_en   = data_i[CTRL_IRQ_EN];
         ctrl_d.auto_clr = data_i[CTRL_AUTO_CLR];
      end

      // Write-1-to-clear first, then OR in new events so a set wins.
      match_d = (match_q & ~(wr_status & data_i[ST_MATCH])) | match_hit;
      ovf_d   = (ovf_q   & ~(wr_status & data_i[ST_OVF]))   | (wr_fifo & f_full);
      unf_d   = (unf_q   & ~(wr_status & data_i[ST_UNF]))   | (rd_fifo & f_empty);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 8; i++) scratch_q[i] <= '0;
         count_q <= '0;
         cmp_q   <= '0;
         ctrl_q  <= '0;
         match_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         if (wr && is_scratch(addr)) scratch_q[addr[2:0]] <= data_i;
         count_q <= count_d;
         cmp_q   <= cmp_d;
         ctrl_q  <= ctrl_d;
         match_q <= match_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_comb begin
      status_v                   = '0;
      status_v[ST_MATCH]         = match_q;
      status_v[ST_EMPTY]         = f_empty;
      status_v[ST_FULL]          = f_full;
      status_v[ST_OVF]           = ovf_q;
      status_v[ST_CNT_LO +: 3]   = 3'(f_count);
      status_v[ST_UNF]           = unf_q;
   end

   always_comb begin
      rdata = '0;
      if (is_scratch(addr)) begin
         rdata = scratch_q[addr[2:0]];
      end else begin
         case (addr)
            A_COUNT:  rdata = count_q;
            A_CMP:    rdata = cmp_q;
            A_CTRL:   rdata = LEN'(ctrl_q);
            A_STATUS: rdata = LEN'(status_v);
            A_FIFO:   rdata = f_empty ? '0 : f_dout;
            default:  rdata = '0;
         endcase
      end
   end

   assign data_oe = rd;
   assign data_o  = rd ? rdata : '0;
   assign irq     = match_q & ctrl_q.irq_en;

endmodule

// File: tb/tb_io_responder.sv
// -----------------------------------------------------------------------------
// tb_io_responder
// Bench for io_responder: directed register-map scenarios with literal
// expectations, followed by randomized bus traffic against a behavioural
// register-map model.
// -----------------------------------------------------------------------------
module tb_io_responder;

   localparam int unsigned LEN   = 16;
   localparam int unsigned DEPTH = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           en_cs, en_w;
   logic [3:0]     addr;
   logic [LEN-1:0] data_i;
   logic [LEN-1:0] data_o;
   logic           data_oe, irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_responder #(.LEN(LEN), .FDEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .en_cs   (en_cs),
      .en_w    (en_w),
      .addr    (addr),
      .data_i  (data_i),
      .data_o  (data_o),
      .data_oe (data_oe),
      .irq     (irq)
   );

   // ---------------- behavioural model ----------------
   logic [15:0] m_scr [8];
   logic [15:0] m_count, m_cmp;
   bit          m_tmr, m_irqen, m_auto;
   bit          m_match, m_ovf, m_unf;
   logic [15:0] m_q [$];

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_scr[i] = 16'h0;
      m_count = 16'h0; m_cmp = 16'h0;
      m_tmr = 0; m_irqen = 0; m_auto = 0;
      m_match = 0; m_ovf = 0; m_unf = 0;
      m_q.delete();
   endtask

   task automatic model_step();
      bit          wr, rd, hit;
      logic [15:0] nxt;
      wr  = en_cs && en_w;
      rd  = en_cs && !en_w;
      hit = m_tmr && (m_count == m_cmp);
      nxt = m_count;
      if (m_tmr) nxt = (hit && m_auto) ? 16'h0 : 16'((32'(m_count) + 1) % 65536);
      if (wr) begin
         if (addr < 4'h8) m_scr[addr[2:0]] = data_i;
         else case (addr)
            4'h8: nxt = data_i;
            4'h9: m_cmp = data_i;
            4'hA: begin m_tmr = data_i[0]; m_irqen = data_i[1]; m_auto = data_i[2]; end
            4'hB: begin
               if (data_i[0]) m_match = 0;
               if (data_i[3]) m_ovf = 0;
               if (data_i[7]) m_unf = 0;
            end
            4'hC: if (m_q.size() == DEPTH) m_ovf = 1; else m_q.push_back(data_i);
            default: ;
         endcase
      end
      if (rd && addr == 4'hC) begin
         if (m_q.size() == 0) m_unf = 1;
         else void'(m_q.pop_front());
      end
      if (hit) m_match = 1;
      m_count = nxt;
   endtask

   function automatic logic [15:0] exp_read(input logic [3:0] a);
      int n;
      n = m_q.size();
      if (a < 4'h8) return m_scr[a[2:0]];
      case (a)
         4'h8: return m_count;
         4'h9: return m_cmp;
         4'hA: return {13'h0, m_auto, m_irqen, m_tmr};
         4'hB: return {8'h0, m_unf, 3'(n), m_ovf, (n == DEPTH), (n == 0), m_match};
         4'hC: return (n == 0) ? 16'h0 : m_q[0];
         default: return 16'h0;
      endcase
   endfunction

   always @(posedge rst) model_clear();
   always @(posedge clk) if (!rst) model_step();

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Every negedge: outputs against the model.
   always @(negedge clk) begin
      bit rd_now;
      rd_now = en_cs && !en_w;
      chk("data_oe", 32'(data_oe), 32'(rd_now));
      chk("data_o", 32'(data_o), rd_now ? 32'(exp_read(addr)) : 32'h0);
      chk("irq", 32'(irq), 32'(m_match && m_irqen));
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      en_cs = 0; en_w = 0; addr = 4'h0; data_i = 16'h0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
      en_cs = 1; en_w = 1; addr = a; data_i = d;
      tick();
      idle();
   endtask

   task automatic rd_set(input logic [3:0] a);
      en_cs = 1; en_w = 0; addr = a; data_i = 16'h0;
      #1;
   endtask

   initial begin
      logic [3:0] pick [7];
      pick = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hC, 4'hC};

      rst = 1;
      idle();
      model_clear();
      #1;
      chk("rst_oe", 32'(data_oe), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_data", 32'(data_o), 32'h0);
      rd_set(4'hB);
      chk("rst_oe_follow", 32'(data_oe), 32'h1);
      chk("rst_status", 32'(data_o), 32'h0002);
      idle();
      @(posedge clk); @(posedge clk); #3 rst = 0;
      tick();

      // Scratch write/read
      bus_wr(4'h3, 16'h1234);
      rd_set(4'h3);
      chk("scratch_rd", 32'(data_o), 32'h1234);
      chk("scratch_oe", 32'(data_oe), 32'h1);
      idle();

      // Counter wrap and write override
      bus_wr(4'hA, 16'h0001);
      bus_wr(4'h8, 16'hFFFE);
      rd_set(4'h8);
      chk("cnt_fffe", 32'(data_o), 32'hFFFE);
      tick();
      chk("cnt_ffff", 32'(data_o), 32'hFFFF);
      tick();
      chk("cnt_wrap", 32'(data_o), 32'h0000);
      bus_wr(4'h8, 16'h0100);
      rd_set(4'h8);
      chk("cnt_override", 32'(data_o), 32'h0100);
      idle();
      bus_wr(4'hA, 16'h0000);

      // Compare match with auto-clear: COUNT cycles 0..5
      bus_wr(4'h9, 16'h0005);
      bus_wr(4'h8, 16'h0000);
      bus_wr(4'hB, 16'h0089);
      bus_wr(4'hA, 16'h0007);
      rd_set(4'h8);
      for (int k = 0; k < 14; k++) begin
         chk("cycle_count", 32'(data_o), 32'(k % 6));
         chk("cycle_irq", 32'(irq), 32'(k >= 6));
         tick();
      end
      rd_set(4'hB);
      chk("match_status", 32'(data_o), 32'h0003);
      idle();

      // FIFO overflow / drain / underflow
      bus_wr(4'hA, 16'h0000);
      for (int i = 0; i < 5; i++) bus_wr(4'hC, 16'(16'hA + i));
      rd_set(4'hB);
      chk("fifo_full_status", 32'(data_o & 16'h00FE), 32'h004C);
      idle();
      rd_set(4'hC);
      for (int i = 0; i < 4; i++) begin
         chk("fifo_pop", 32'(data_o), 32'(16'hA + i));
         tick();
      end
      chk("fifo_pop_empty", 32'(data_o), 32'h0);
      tick();
      idle();
      rd_set(4'hB);
      chk("fifo_unf_status", 32'(data_o & 16'h00FE), 32'h008A);
      idle();

      // Set wins over write-1-to-clear
      bus_wr(4'hB, 16'h0001);
      bus_wr(4'h8, 16'h0000);
      bus_wr(4'hA, 16'h0007);
      repeat (5) tick();
      bus_wr(4'hB, 16'h0089);
      rd_set(4'hB);
      chk("set_wins", 32'(data_o), 32'h0003);
      idle();

      // Asynchronous reset in the middle of a write
      bus_wr(4'hA, 16'h0000);
      bus_wr(4'h8, 16'h0042);
      bus_wr(4'hC, 16'h0011);
      bus_wr(4'hC, 16'h0022);
      rd_set(4'h8);
      chk("pre_rst_count", 32'(data_o), 32'h0042);
      en_cs = 1; en_w = 1; addr = 4'h3; data_i = 16'hDEAD;
      #1 rst = 1;
      #1;
      chk("arst_irq", 32'(irq), 32'h0);
      chk("arst_oe", 32'(data_oe), 32'h0);
      chk("arst_data", 32'(data_o), 32'h0);
      en_w = 0; addr = 4'hB; #1;
      chk("arst_status", 32'(data_o), 32'h0002);
      addr = 4'h8; #1;
      chk("arst_count", 32'(data_o), 32'h0);
      addr = 4'h3; #1;
      chk("arst_scratch", 32'(data_o), 32'h0);
      idle();
      @(posedge clk); #3 rst = 0;
      tick();

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         en_cs = ($urandom_range(0, 3) != 0);
         en_w  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 3) addr = 4'($urandom_range(0, 15));
         else addr = pick[$urandom_range(0, 6)];
         data_i = 16'($urandom);
         if (addr == 4'h8 || addr == 4'h9) data_i = 16'($urandom_range(0, 20));
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1;
            @(posedge clk); #3 rst = 0;
         end
         tick();
      end
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
